// File: rtl/mul_iter_nw_if.sv
// Request/response bundle for the iterative multiplier.
// The master side issues operands; the slave side returns ready, finish and the product.
interface mul_iter_nw_if #(
  parameter int DATA_W = 256
);
  logic                  mul_vld_i;
  logic                  mul_sqr_i;
  logic [DATA_W-1:0]     mul_a_i;
  logic [DATA_W-1:0]     mul_b_i;
  logic                  mul_rdy_o;
  logic                  mul_fin_o;
  logic [2*DATA_W-1:0]   mul_r_o;

  modport master (
    output mul_vld_i, mul_sqr_i, mul_a_i, mul_b_i,
    input  mul_rdy_o, mul_fin_o, mul_r_o
  );

  modport slave (
    input  mul_vld_i, mul_sqr_i, mul_a_i, mul_b_i,
    output mul_rdy_o, mul_fin_o, mul_r_o
  );
endinterface

// File: rtl/mul_iter_nw.sv
// Iterative unsigned full-word multiplier: one registered LIMB_W x LIMB_W product per cycle
// is shifted into a 2*DATA_W accumulator; squaring mode skips the mirrored partial products.
module mul_iter_nw #(
  parameter int DATA_W = 256,
  parameter int LIMB_W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_iter_nw_if.slave bus
);
  localparam int N  = DATA_W / LIMB_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 2 * DATA_W;
  localparam int PW = 2 * LIMB_W;
  localparam int SW = $clog2(AW) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              sqr_q, sqr_d;
  logic [CW-1:0]     i_q, i_d, j_q, j_d;
  logic [PW-1:0]     p_q, p_d;
  logic [CW-1:0]     pi_q, pi_d, pj_q, pj_d;
  logic              pv_q, pv_d;
  logic [AW-1:0]     acc_q, acc_d, r_q, r_d;
  logic              fin_q, fin_d;

  logic [LIMB_W-1:0] a_limb [N];
  logic [LIMB_W-1:0] b_limb [N];
  logic [SW-1:0]     sh;
  logic [AW-1:0]     term;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_limb
      assign a_limb[gi] = a_q[gi*LIMB_W +: LIMB_W];
      assign b_limb[gi] = b_q[gi*LIMB_W +: LIMB_W];
    end
  endgenerate

  // Off-diagonal squaring terms appear once, so they are doubled by one extra shift bit.
  assign sh   = SW'((32'(pi_q) + 32'(pj_q)) * LIMB_W) + SW'(sqr_q && (pi_q != pj_q));
  assign term = AW'(p_q) << sh;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sqr_d   = sqr_q;
    i_d     = i_q;
    j_d     = j_q;
    p_d     = p_q;
    pi_d    = pi_q;
    pj_d    = pj_q;
    pv_d    = 1'b0;
    acc_d   = acc_q;
    r_d     = r_q;
    fin_d   = 1'b0;

    if (pv_q) acc_d = acc_q + term;

    case (state_q)
      IDLE: begin
        if (bus.mul_vld_i) begin
          a_d     = bus.mul_a_i;
          b_d     = bus.mul_sqr_i ? bus.mul_a_i : bus.mul_b_i;
          sqr_d   = bus.mul_sqr_i;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d  = PW'(a_limb[i_q]) * PW'(b_limb[j_q]);
        pi_d = i_q;
        pj_d = j_q;
        pv_d = 1'b1;
        if (j_q == LAST) begin
          if (i_q == LAST) begin
            state_d = DRAIN;
          end else begin
            i_d = i_q + CW'(1);
            j_d = sqr_q ? (i_q + CW'(1)) : '0;
          end
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      DRAIN: begin
        r_d     = acc_d;
        fin_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sqr_q   <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      p_q     <= '0;
      pi_q    <= '0;
      pj_q    <= '0;
      pv_q    <= 1'b0;
      acc_q   <= '0;
      r_q     <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sqr_q   <= sqr_d;
      i_q     <= i_d;
      j_q     <= j_d;
      p_q     <= p_d;
      pi_q    <= pi_d;
      pj_q    <= pj_d;
      pv_q    <= pv_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      fin_q   <= fin_d;
    end
  end

  assign bus.mul_rdy_o = (state_q == IDLE);
  assign bus.mul_fin_o = fin_q;
  assign bus.mul_r_o   = r_q;
endmodule

// File: tb/tb_mul_iter_nw.sv
// Drives one shared stimulus stream into a 64-bit-limb and a 128-bit-limb instance and
// checks each cycle against a product/latency reference model kept per instance.
module tb_mul_iter_nw;
  localparam int DW = 256;
  localparam int RW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vld = 1'b0;
  logic          sqr = 1'b0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [1:0]    rdy_all;
  logic [RW-1:0] r_all [2];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_op();
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < DW / 32; k++) begin
      case ($urandom_range(0, 3))
        0:       v[k*32 +: 32] = 32'h0;
        1:       v[k*32 +: 32] = 32'hFFFF_FFFF;
        default: v[k*32 +: 32] = $urandom();
      endcase
    end
    return v;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LW    = (gi == 0) ? 64 : 128;
      localparam int NL    = DW / LW;
      localparam int LAT_N = NL * NL + 2;
      localparam int LAT_S = NL * (NL + 1) / 2 + 2;

      mul_iter_nw_if #(.DATA_W(DW)) bus ();
      mul_iter_nw #(.DATA_W(DW), .LIMB_W(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
      );

      assign bus.mul_vld_i = vld;
      assign bus.mul_sqr_i = sqr;
      assign bus.mul_a_i   = a;
      assign bus.mul_b_i   = b;
      assign rdy_all[gi]   = bus.mul_rdy_o;
      assign r_all[gi]     = bus.mul_r_o;

      logic [RW-1:0] q_exp [$];
      int            q_cyc [$];
      int            q_lat [$];
      logic [RW-1:0] held = '0;

      // Reference: each accepted request finishes exactly LAT cycles later with a*b (or a*a).
      always @(negedge clk) begin
        logic          ef;
        logic [RW-1:0] ea, eb;
        if (!rst_n) begin
          q_exp.delete();
          q_cyc.delete();
          q_lat.delete();
          held = '0;
        end
        ef = (q_cyc.size() != 0) && ((cyc - q_cyc[0]) == q_lat[0]);
        chk_val($sformatf("fin_L%0d", LW), RW'(bus.mul_fin_o), RW'(ef));
        if (ef) begin
          held = q_exp.pop_front();
          void'(q_cyc.pop_front());
          void'(q_lat.pop_front());
        end
        chk_val($sformatf("r_L%0d", LW), bus.mul_r_o, held);
        chk_val($sformatf("rdy_L%0d", LW), RW'(bus.mul_rdy_o), RW'(q_cyc.size() == 0));
        if (rst_n && vld && q_cyc.size() == 0) begin
          ea = RW'(a);
          eb = sqr ? RW'(a) : RW'(b);
          q_exp.push_back(ea * eb);
          q_cyc.push_back(cyc);
          q_lat.push_back(sqr ? LAT_S : LAT_N);
        end
      end
    end
  endgenerate

  task automatic send(input logic [DW-1:0] ta, input logic [DW-1:0] tb, input logic ts);
    int n;
    @(posedge clk); #1;
    vld = 1'b1; a = ta; b = tb; sqr = ts;
    @(posedge clk); #1;
    vld = 1'b0; a = rnd_op(); b = rnd_op(); sqr = 1'($urandom_range(0, 1));
    n = 0;
    while (rdy_all != 2'b11 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk_val("idle_wait", RW'(rdy_all), RW'(2'b11));
  endtask

  logic [DW-1:0] ta;
  logic [RW-1:0] er;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    send(DW'(3), DW'(5), 1'b0);
    chk_val("small_L64", r_all[0], RW'(15));
    chk_val("small_L128", r_all[1], RW'(15));

    er = ({RW{1'b0}} - (RW'(1) << 257)) + RW'(1);
    send({DW{1'b1}}, {DW{1'b1}}, 1'b0);
    chk_val("max_norm", r_all[0], er);
    send({DW{1'b1}}, DW'(0), 1'b1);
    chk_val("max_sqr", r_all[0], er);
    chk_val("max_sqr_L128", r_all[1], er);

    ta = (DW'(1) << 255) | (DW'(1) << 64) | DW'(1);
    send(ta, DW'(16'hDEAD), 1'b1);
    send(ta, ta, 1'b0);
    ta = DW'(1) << 255;
    send(ta, DW'(16'hDEAD), 1'b1);
    chk_val("pow510", r_all[0], RW'(1) << 510);

    // Abort mid-run; the monitor then expects no finish while the pipeline is empty.
    @(posedge clk); #1;
    vld = 1'b1; a = rnd_op(); b = rnd_op(); sqr = 1'b0;
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_val("rst_rdy", RW'(rdy_all), RW'(2'b11));
    chk_val("rst_r", r_all[0], '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (25) @(posedge clk);
    send(rnd_op(), rnd_op(), 1'b0);

    // Request held high continuously with changing operands.
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      vld = 1'b1; a = rnd_op(); b = rnd_op(); sqr = 1'b0;
    end

    for (int k = 0; k < 20000; k++) begin
      @(posedge clk); #1;
      vld = ($urandom_range(0, 3) != 0);
      sqr = 1'($urandom_range(0, 1));
      a   = rnd_op();
      b   = rnd_op();
    end
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk_val("drained", RW'(rdy_all), RW'(2'b11));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mul_iter_nw.md
Name: mul_iter_nw

Overview:
- Parametrised iterative full-word unsigned multiplier for the SM2 modular-multiply path.
- Computes a 2*DATA_W product (or a square) by streaming limb partial products through a single registered LIMB_W x LIMB_W multiplier into a shifted accumulator.
- Trades latency for area against the four-way parallel full-word multiplier.
- Provides a real ready/finish handshake and a squaring mode that skips symmetric partial products.

Parameters:
- DATA_W, 256, operand width; must be a multiple of LIMB_W.
- LIMB_W, 64, limb width and width of the internal multiplier operands.
- N (localparam), DATA_W/LIMB_W, limb count; default 4.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mul_vld_i  in  1  operation request; sampled only while mul_rdy_o=1.
- mul_sqr_i  in  1  sampled with mul_vld_i; 1 = compute mul_a_i squared, ignore mul_b_i.
- mul_a_i  in  DATA_W  multiplicand.
- mul_b_i  in  DATA_W  multiplier.
- mul_rdy_o  out  1  block can accept a request this cycle.
- mul_fin_o  out  1  one-cycle pulse; mul_r_o is valid from this cycle on.
- mul_r_o  out  2*DATA_W  product; held until the next mul_fin_o.

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE, mul_rdy_o=1, mul_fin_o=0, mul_r_o=0. Operand, accumulator, counter and pipeline registers are cleared. An in-flight operation is discarded with no fin.
- Accept: in cycle T with mul_rdy_o=1 and mul_vld_i=1:
  - latch a, b (a copied into b when sqr) and the sqr flag;
  - clear the accumulator, set i=0, j=0, go to RUN.
- mul_vld_i while mul_rdy_o=0 is ignored with no side effects.
- States:
  - IDLE: mul_rdy_o=1.
  - RUN: mul_rdy_o=0. Each cycle issue one pair (i,j) to the multiplier and register p=a[i]*b[j] (2*LIMB_W bits).
    - Normal mode: i outer 0..N-1, j inner 0..N-1; N*N issues.
    - Sqr mode: j runs i..N-1; N(N+1)/2 issues.
    - After the last issue go to DRAIN.
  - DRAIN: mul_rdy_o=0. Accumulate the final registered product, then return to IDLE.
- Accumulate (one cycle behind issue): acc += p << ((i+j)*LIMB_W), with i and j pipelined alongside p.
  - In sqr mode, when i!=j, the shift gains one extra bit (doubling).
  - The accumulator is 2*DATA_W bits; the final sum never overflows, so no carry-out is kept.
- Finish: on the edge that completes the last accumulation:
  - mul_r_o <= final acc;
  - mul_fin_o=1 for exactly one cycle;
  - state=IDLE.
- Latency: with K=N*N (normal) or N(N+1)/2 (sqr), mul_fin_o is high in cycle T+K+2. Defaults give 18 (normal) and 12 (sqr).
- Back-to-back: mul_rdy_o=1 in the mul_fin_o cycle. A new request accepted in that cycle starts at once.
- mul_r_o holds the previous result until the new operation's fin. It is never partially updated.
- Inputs need not be held after the accept cycle.
- mul_sqr_i and mul_b_i are don't-care when not accepted. In sqr mode mul_b_i is ignored entirely.

Test Plan:
- Reset values: assert rst_n=0 mid-RUN, 5 cycles after an accept -> mul_rdy_o=1, mul_fin_o=0, mul_r_o=0 immediately. No fin follows release. The next request completes normally.
- Small product: a=3, b=5, normal, accept at T -> mul_fin_o high only at T+18, mul_r_o=15, mul_rdy_o low T+1..T+17.
- Max operands: a=b=2^256-1, normal -> mul_r_o = 2^512 - 2^257 + 1. Repeat with sqr=1 -> same value, fin at T+12.
- Sqr cross-term check:
  - a=2^255+2^64+1, sqr=1, b=0xDEAD (ignored) -> mul_r_o = a*a, matching the normal-mode result with b=a.
  - a=2^255 -> 2^510.
- Handshake:
  - mul_vld_i held high continuously with changing operands -> only requests in mul_rdy_o=1 cycles are accepted, each result matches its accepted operands;
  - back-to-back fin pulses are 18 cycles apart;
  - mul_r_o is stable between fins.
- Parametrisation: LIMB_W=128, DATA_W=256 -> normal latency 6, sqr latency 5. Random 1000-vector compare against a reference model in both modes. Repeat at default parameters.
